adt7420_sampler: RTL and testbench

Transaction sequencer that sits directly upstream of the I2C master and drives its request interface to run an ADT7420 temperature sensor autonomously. After reset it configures the sensor for 16-bit resolution. It then issues a 2-byte temperature read every sample period and publishes the assembled raw temperature word with a one-cycle valid strobe. It also detects slave NACKs, short reads and hung transactions, and reports them.

---
 rtl/adt7420_sampler.sv | 141 ++++++++++++++
 tb/tb_adt7420_sampler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_sampler.sv
// adt7420_sampler: configures an ADT7420 for 16-bit mode, then reads it every sample period (define NACK_RETRY_EN for NACK retries)
module adt7420_sampler #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h4B,
  parameter int         SAMPLE_PERIOD  = 100_000_000,
  parameter int         TIMEOUT_CYCLES = 200_000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        i_enable,
  output logic [7:0]  o_addr_w_rw,
  output logic [15:0] o_sub_addr,
  output logic        o_sub_len,
  output logic [23:0] o_byte_len,
  output logic [7:0]  o_data_write,
  output logic        o_req_trans,
  input  logic [7:0]  i_data_out,
  input  logic        i_valid_out,
  input  logic        i_busy,
  input  logic        i_nack,
  output logic [15:0] o_temp,
  output logic        o_temp_valid,
  output logic        o_error,
  output logic [1:0]  o_err_code,
  output logic        o_configured
);
  typedef enum logic [2:0] {CFG_REQ, CFG_WAIT, WAIT_PERIOD, RD_REQ, RD_WAIT, PUBLISH, ERR} state_t;
  localparam int CMAX = SAMPLE_PERIOD > TIMEOUT_CYCLES ? SAMPLE_PERIOD : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0] nbytes, nbytes_now, err_q, err_d;
  logic [15:0] rd_buf;
  logic nack_q, nack_seen, is_req, is_wait, active, done, timeout, period_done;
  logic cap, cont, req_entry, cfg_ok, can_retry;
  assign o_sub_len = 1'b0;
  always_comb begin
    is_req = state == CFG_REQ || state == RD_REQ;
    is_wait = state == CFG_WAIT || state == RD_WAIT;
    // the reset cycle sits in CFG_REQ before the request is raised; don't time it
    active = is_req ? o_req_trans : is_wait;
    nack_seen = nack_q | i_nack;
    done = is_wait && !i_busy;
    timeout = active && cnt == CW'(TIMEOUT_CYCLES - 1);
    period_done = cnt == CW'(SAMPLE_PERIOD - 1);
    cap = i_valid_out && (state == RD_REQ || state == RD_WAIT) && nbytes != 2'd2;
    nbytes_now = nbytes + {1'b0, cap};
    cfg_ok = state == CFG_WAIT && done && !nack_seen;
  end
  always_comb begin
    state_d = state;
    err_d = err_q;
    case (state)
      CFG_REQ, RD_REQ: begin
        if (o_req_trans && i_busy) state_d = state == CFG_REQ ? CFG_WAIT : RD_WAIT;
        else if (timeout) begin
          state_d = ERR;
          err_d = 2'b11;
        end
      end
      CFG_WAIT, RD_WAIT: begin
        if (done) begin
          if (nack_seen) begin
            state_d = can_retry ? (state == CFG_WAIT ? CFG_REQ : RD_REQ) : ERR;
            err_d = can_retry ? err_q : 2'b01;
          end else if (state == RD_WAIT && nbytes_now != 2'd2) begin
            state_d = ERR;
            err_d = 2'b10;
          end else state_d = state == RD_WAIT ? PUBLISH : i_enable ? RD_REQ : WAIT_PERIOD;
        end else if (timeout) begin
          state_d = ERR;
          err_d = 2'b11;
        end
      end
      WAIT_PERIOD: if (period_done && (!o_configured || i_enable)) state_d = o_configured ? RD_REQ : CFG_REQ;
      PUBLISH: state_d = WAIT_PERIOD;
      ERR: state_d = WAIT_PERIOD;
      default: state_d = CFG_REQ;
    endcase
  end
  always_comb begin
    cont = state_d == state || (state == CFG_REQ && state_d == CFG_WAIT) || (state == RD_REQ && state_d == RD_WAIT);
    cnt_d = !cont ? '0 : state == WAIT_PERIOD ? (period_done ? cnt : cnt + CW'(1)) : active ? cnt + CW'(1) : '0;
    req_entry = (state_d == CFG_REQ || state_d == RD_REQ) && state_d != state;
  end
`ifdef NACK_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry;
  assign can_retry = retry < RW'(MAX_RETRY);
  always_ff @(posedge i_clk or posedge reset)
    if (reset) retry <= '0;
    else if (state == ERR || (done && !nack_seen)) retry <= '0;
    else if (done && nack_seen && can_retry) retry <= retry + RW'(1);
`else
  assign can_retry = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      state <= CFG_REQ;
      cnt <= '0;
      nack_q <= 1'b0;
      nbytes <= 2'd0;
      rd_buf <= 16'h0000;
      err_q <= 2'b00;
      o_addr_w_rw <= 8'h00;
      o_sub_addr <= 16'h0000;
      o_byte_len <= 24'd0;
      o_data_write <= 8'h00;
      o_req_trans <= 1'b0;
      o_temp <= 16'h0000;
      o_temp_valid <= 1'b0;
      o_error <= 1'b0;
      o_err_code <= 2'b00;
      o_configured <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      err_q <= err_d;
      nack_q <= req_entry ? 1'b0 : nack_q | ((is_req || is_wait) && i_nack);
      nbytes <= req_entry ? 2'd0 : nbytes_now;
      if (cap && nbytes == 2'd0) rd_buf[15:8] <= i_data_out;
      if (cap && nbytes == 2'd1) rd_buf[7:0] <= i_data_out;
      o_req_trans <= state_d == CFG_REQ || state_d == RD_REQ;
      if (state_d == CFG_REQ) begin
        o_addr_w_rw <= {SLAVE_ADDR, 1'b0};
        o_sub_addr <= 16'h0003;
        o_byte_len <= 24'd1;
        o_data_write <= 8'h80;
      end else if (state_d == RD_REQ) begin
        o_addr_w_rw <= {SLAVE_ADDR, 1'b1};
        o_sub_addr <= 16'h0000;
        o_byte_len <= 24'd2;
      end
      o_temp_valid <= state == PUBLISH;
      if (state == PUBLISH) o_temp <= rd_buf;
      o_error <= state == ERR;
      if (state == ERR) o_err_code <= err_q;
      o_configured <= o_configured | cfg_ok;
    end
  end
endmodule

// File: tb/tb_adt7420_sampler.sv
// tb_adt7420_sampler: directed vector bench for adt7420_sampler with a scripted I2C master
module tb_adt7420_sampler;
  localparam int S = 20;
  localparam int T = 64;
  logic clk = 1'b0, reset = 1'b1, i_enable = 1'b0;
  logic [7:0] i_data_out = 8'h00;
  logic i_valid_out = 1'b0, i_busy = 1'b0, i_nack = 1'b0;
  logic [7:0] o_addr_w_rw, o_data_write;
  logic [15:0] o_sub_addr, o_temp;
  logic [23:0] o_byte_len;
  logic [1:0] o_err_code;
  logic o_sub_len, o_req_trans, o_temp_valid, o_error, o_configured;
  int n_tests = 0, n_fail = 0;
  bit have_pulse = 1'b0;
  time pulse_t = 0;
  typedef struct {
    logic [7:0] b0, b1;
    int n;
    bit nack, same;
    int exp_v, exp_e;
    logic [15:0] exp_temp;
    logic [1:0] exp_code;
  } vec_t;
  vec_t vecs[7];
  int nvec;
  always #5 clk = ~clk;
  adt7420_sampler #(.SLAVE_ADDR(7'h4B), .SAMPLE_PERIOD(S), .TIMEOUT_CYCLES(T), .MAX_RETRY(3)) dut (
    .i_clk(clk), .reset(reset), .i_enable(i_enable),
    .o_addr_w_rw(o_addr_w_rw), .o_sub_addr(o_sub_addr), .o_sub_len(o_sub_len),
    .o_byte_len(o_byte_len), .o_data_write(o_data_write), .o_req_trans(o_req_trans),
    .i_data_out(i_data_out), .i_valid_out(i_valid_out), .i_busy(i_busy), .i_nack(i_nack),
    .o_temp(o_temp), .o_temp_valid(o_temp_valid), .o_error(o_error),
    .o_err_code(o_err_code), .o_configured(o_configured)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_req(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      cyc = i;
      ok = o_req_trans;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL req_wait: no request within 200 cycles");
    end
  endtask
  task automatic monitor(input time bt, output int nv, output int ne, output int lat);
    nv = 0;
    ne = 0;
    lat = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_temp_valid || o_error) begin
        if (lat < 0) lat = int'(($time - bt) / 10);
        pulse_t = $time;
        have_pulse = 1'b1;
      end
      nv += int'(o_temp_valid);
      ne += int'(o_error);
    end
  endtask
  task automatic do_read(input vec_t v);
    bit ok;
    int cyc, nv, ne, lat;
    time bt;
    wait_req(ok, cyc);
    if (!ok) return;
    chk("rd_addr", 32'(o_addr_w_rw), 32'h97);
    chk("rd_sub", 32'(o_sub_addr), 32'h0);
    chk("rd_len", 32'(o_byte_len), 32'd2);
    if (have_pulse) chk("period_gap", 32'(int'(($time - pulse_t) / 10)), 32'(S));
    i_busy = 1'b1;
    @(negedge clk);
    chk("req_drop", 32'(o_req_trans), 32'd0);
    i_nack = v.nack;
    @(negedge clk);
    i_nack = 1'b0;
    bt = $time;
    for (int b = 0; b < v.n; b++) begin
      i_data_out = b == 0 ? v.b0 : b == 1 ? v.b1 : 8'h5A;
      i_valid_out = 1'b1;
      if (v.same && b == v.n - 1) begin
        i_busy = 1'b0;
        bt = $time;
      end
      @(negedge clk);
      i_valid_out = 1'b0;
    end
    if (i_busy) begin
      i_busy = 1'b0;
      bt = $time;
    end
    monitor(bt, nv, ne, lat);
    chk("valid_cnt", 32'(nv), 32'(v.exp_v));
    chk("err_cnt", 32'(ne), 32'(v.exp_e));
    chk("latency", 32'(lat), 32'd2);
    chk("temp", 32'(o_temp), 32'(v.exp_temp));
    if (v.exp_e != 0) chk("err_code", 32'(o_err_code), 32'(v.exp_code));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    int cyc, n, nv, ne, lat;
    vecs[0] = '{8'h0C, 8'h80, 2, 1'b0, 1'b0, 1, 0, 16'h0C80, 2'b00};
    vecs[1] = '{8'hFF, 8'h80, 2, 1'b0, 1'b0, 1, 0, 16'hFF80, 2'b00};
    vecs[2] = '{8'h12, 8'h34, 3, 1'b0, 1'b0, 1, 0, 16'h1234, 2'b00};
    vecs[3] = '{8'hAA, 8'hBB, 1, 1'b0, 1'b0, 0, 1, 16'h1234, 2'b10};
    vecs[4] = '{8'h0C, 8'h80, 2, 1'b0, 1'b1, 1, 0, 16'h0C80, 2'b00};
    vecs[5] = '{8'h00, 8'h00, 0, 1'b0, 1'b0, 0, 1, 16'h0C80, 2'b10};
    vecs[6] = '{8'h55, 8'h66, 2, 1'b1, 1'b0, 0, 1, 16'h0C80, 2'b01};
`ifdef NACK_RETRY_EN
    nvec = 6;
`else
    nvec = 7;
`endif
    i_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(o_req_trans), 32'd0);
    chk("rst_addr", 32'(o_addr_w_rw), 32'h0);
    chk("rst_temp", 32'(o_temp), 32'h0);
    chk("rst_valid", 32'(o_temp_valid), 32'd0);
    chk("rst_err", 32'(o_err_code), 32'd0);
    chk("rst_cfg", 32'(o_configured), 32'd0);
    reset = 1'b0;
    wait_req(ok, cyc);
    chk("cfg_addr", 32'(o_addr_w_rw), 32'h96);
    chk("cfg_sub", 32'(o_sub_addr), 32'h0003);
    chk("cfg_len", 32'(o_byte_len), 32'd1);
    chk("cfg_data", 32'(o_data_write), 32'h80);
    chk("cfg_sublen", 32'(o_sub_len), 32'd0);
    i_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("configured", 32'(o_configured), 32'd1);
    for (int i = 0; i < nvec; i++) do_read(vecs[i]);
    wait_req(ok, cyc);
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!o_req_trans) break;
      n++;
    end
    chk("timeout_len", 32'(n), 32'(T));
    @(negedge clk);
    chk("timeout_err", 32'(o_error), 32'd1);
    chk("timeout_code", 32'(o_err_code), 32'b11);
`ifdef NACK_RETRY_EN
    for (int r = 0; r < 3; r++) begin
      wait_req(ok, cyc);
      if (r > 0) chk("retry_immediate", 32'(cyc < 3), 32'd1);
      i_busy = 1'b1;
      @(negedge clk);
      i_nack = r < 2;
      @(negedge clk);
      i_nack = 1'b0;
      if (r == 2) begin
        for (int b = 0; b < 2; b++) begin
          i_data_out = b == 0 ? 8'h19 : 8'h00;
          i_valid_out = 1'b1;
          @(negedge clk);
          i_valid_out = 1'b0;
        end
      end
      i_busy = 1'b0;
    end
    monitor($time, nv, ne, lat);
    chk("retry_valid", 32'(nv), 32'd1);
    chk("retry_err", 32'(ne), 32'd0);
    chk("retry_temp", 32'(o_temp), 32'h1900);
`endif
    wait_req(ok, cyc);
    i_busy = 1'b1;
    @(negedge clk);
    i_data_out = 8'h11;
    i_valid_out = 1'b1;
    @(negedge clk);
    i_valid_out = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("arst_req", 32'(o_req_trans), 32'd0);
    chk("arst_temp", 32'(o_temp), 32'h0);
    chk("arst_cfg", 32'(o_configured), 32'd0);
    chk("arst_addr", 32'(o_addr_w_rw), 32'h0);
    i_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_req(ok, cyc);
    chk("restart_addr", 32'(o_addr_w_rw), 32'h96);
    chk("restart_sub", 32'(o_sub_addr), 32'h0003);
    chk("restart_cfg", 32'(o_configured), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
